captcha_answer_checker: RTL

//  Sits directly downstream of the on-screen-keyboard input stage. Captures the six 5-bit letter

---
 rtl/captcha_answer_checker_if.sv | 33 +++
 rtl/captcha_answer_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/captcha_answer_checker_if.sv
// Answer bundle between the keyboard input stage/target generator and the answer checker.
// The slave side is the checker; the master side drives answers and observes verdicts.
interface captcha_answer_checker_if;
  logic        answer_done;
  logic [4:0]  first_inp;
  logic [4:0]  second_inp;
  logic [4:0]  third_inp;
  logic [4:0]  fourth_inp;
  logic [4:0]  fifth_inp;
  logic [4:0]  sixth_inp;
  logic [29:0] target_word;
  logic        result_valid;
  logic        captcha_passed;
  logic        captcha_failed;
  logic [2:0]  mismatch_count;
  logic [1:0]  attempts_left;
  logic        lockout_active;
  logic        input_clear;

  modport slave (
    input  answer_done, first_inp, second_inp, third_inp, fourth_inp, fifth_inp, sixth_inp,
    input  target_word,
    output result_valid, captcha_passed, captcha_failed, mismatch_count, attempts_left,
    output lockout_active, input_clear
  );

  modport master (
    output answer_done, first_inp, second_inp, third_inp, fourth_inp, fifth_inp, sixth_inp,
    output target_word,
    input  result_valid, captcha_passed, captcha_failed, mismatch_count, attempts_left,
    input  lockout_active, input_clear
  );
endinterface

// File: rtl/captcha_answer_checker.sv
// Compares the six captured letters with the target word one letter per clock, issues the verdict,
// counts failures and holds the input stage in reset during retry and timed lockout.
module captcha_answer_checker #(
  parameter int          MAX_ROUND      = 6,
  parameter logic [4:0]  NULL_SERIAL    = 5'd31,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          LOCKOUT_CYCLES = 100_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  captcha_answer_checker_if.slave   bus
);

  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    COMPARE,
    VERDICT,
    RETRY,
    LOCKOUT,
    PASSED
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [4:0]       entry [MAX_ROUND];
  logic [4:0]       inp_letter [MAX_ROUND];
  logic [4:0]       target_letter [MAX_ROUND];
  logic [2:0]       idx;
  logic [2:0]       mism;
  logic             cur_miss;
  logic             last_attempt;
  logic [CNT_W-1:0] cnt;

  assign rise         = s2 & ~s3;
  assign last_attempt = (bus.attempts_left <= 2'd1);

  always_comb begin
    inp_letter[0] = bus.first_inp;
    inp_letter[1] = bus.second_inp;
    inp_letter[2] = bus.third_inp;
    inp_letter[3] = bus.fourth_inp;
    inp_letter[4] = bus.fifth_inp;
    inp_letter[5] = bus.sixth_inp;
    for (int i = 0; i < MAX_ROUND; i++) begin
      target_letter[i] = bus.target_word[i*5 +: 5];
    end
  end

  // The empty square never matches, even if the target were to contain the same code.
  always_comb begin
    cur_miss = (entry[idx] == NULL_SERIAL) || (entry[idx] != target_letter[idx]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: state_nxt = COMPARE;
      COMPARE: begin
        if (idx == 3'(MAX_ROUND - 1)) begin
          state_nxt = VERDICT;
        end
      end
      VERDICT: begin
        if (mism == 3'd0) begin
          state_nxt = PASSED;
        end else if (last_attempt) begin
          state_nxt = LOCKOUT;
        end else begin
          state_nxt = RETRY;
        end
      end
      RETRY: begin
        if (!s2) begin
          state_nxt = IDLE;
        end
      end
      LOCKOUT: begin
        if (cnt == '0) begin
          state_nxt = RETRY;
        end
      end
      PASSED:  state_nxt = PASSED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1                 <= 1'b0;
      s2                 <= 1'b0;
      s3                 <= 1'b0;
      idx                <= 3'd0;
      mism               <= 3'd0;
      cnt                <= '0;
      for (int i = 0; i < MAX_ROUND; i++) begin
        entry[i] <= NULL_SERIAL;
      end
      bus.result_valid   <= 1'b0;
      bus.captcha_passed <= 1'b0;
      bus.captcha_failed <= 1'b0;
      bus.mismatch_count <= 3'd0;
      bus.attempts_left  <= 2'(MAX_ATTEMPTS);
      bus.lockout_active <= 1'b0;
      bus.input_clear    <= 1'b0;
    end else begin
      s1 <= bus.answer_done;
      s2 <= s1;
      s3 <= s2;

      bus.result_valid   <= 1'b0;
      bus.captcha_failed <= 1'b0;
      // Both control outputs follow the state being entered, so they stay registered.
      bus.lockout_active <= (state_nxt == LOCKOUT);
      bus.input_clear    <= (state_nxt == RETRY) || (state_nxt == LOCKOUT);

      case (state)
        CAPTURE: begin
          for (int i = 0; i < MAX_ROUND; i++) begin
            entry[i] <= inp_letter[i];
          end
          idx  <= 3'd0;
          mism <= 3'd0;
        end
        COMPARE: begin
          if (cur_miss) begin
            mism <= mism + 3'd1;
          end
          idx <= idx + 3'd1;
        end
        VERDICT: begin
          bus.mismatch_count <= mism;
          bus.result_valid   <= 1'b1;
          if (mism == 3'd0) begin
            bus.captcha_passed <= 1'b1;
          end else begin
            bus.captcha_failed <= 1'b1;
            if (bus.attempts_left != 2'd0) begin
              bus.attempts_left <= bus.attempts_left - 2'd1;
            end
            if (last_attempt) begin
              cnt <= CNT_W'(LOCKOUT_CYCLES - 1);
            end
          end
        end
        LOCKOUT: begin
          if (cnt == '0) begin
            bus.attempts_left <= 2'(MAX_ATTEMPTS);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
